// File: rtl/hps_if_pkg.sv
// Shared definitions for the HPS bit-serial image fetch protocol.
// State encodings must stay in step with the HPS software header.
package hps_if_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_READY = 3'd2,
    ST_FETCH = 3'd3,
    ST_DONE  = 3'd4
  } hps_state_t;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int TIMEOUT_DEF  = 1023;

endpackage

// File: rtl/hps_pixel_responder_sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous level, plus one delay flop
// so rise/fall/any-edge are seen exactly once per synchronised change.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_edge
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = o_level & ~r_dly;
  assign o_fall  = ~o_level & r_dly;
  assign o_edge  = o_level ^ r_dly;

endmodule

// File: rtl/hps_pixel_responder.sv
// FPGA-side responder: one FIFO pop per HPS request toggle, selected bit
// presented with a level-matching ack, plus position and error tracking.
module hps_pixel_responder
  import hps_if_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int BIT_SEL     = 0,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iHPS_CLK,
  input  logic        iSTART,
  input  logic [15:0] iPIX_DATA,
  input  logic        iPIX_VALID,
  output logic        oPIX_RD,
  output logic        oIMG_BIT,
  output logic        oACK,
  output logic [9:0]  oROW,
  output logic [9:0]  oCOL,
  output logic        oFRAME_DONE,
  output logic [2:0]  oSTATE,
  output logic        oUNDERRUN,
  output logic        oOVERRUN
);

  localparam int                WAIT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [9:0]        LAST_COL = 10'(H_ACTIVE - 1);
  localparam logic [9:0]        LAST_ROW = 10'(V_ACTIVE - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  logic w_req_s, w_req_edge, w_req_rise, w_req_fall;
  logic w_start_lvl, w_start_rise, w_start_fall, w_start_edge;
  logic w_unused;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .i_async (iHPS_CLK),
    .o_level (w_req_s),
    .o_rise  (w_req_rise),
    .o_fall  (w_req_fall),
    .o_edge  (w_req_edge)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_start_sync (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .i_async (iSTART),
    .o_level (w_start_lvl),
    .o_rise  (w_start_rise),
    .o_fall  (w_start_fall),
    .o_edge  (w_start_edge)
  );

  assign w_unused = ^{w_req_rise, w_req_fall, w_start_lvl, w_start_edge, iPIX_DATA};

  hps_state_t        r_state;
  logic [9:0]        r_row, r_col;
  logic [WAIT_W-1:0] r_wait;
  logic              r_img_bit, r_ack, r_frame_done, r_underrun, r_overrun;

  // Pop is combinational on the FIFO valid so it can never fire on an empty FIFO.
  assign oPIX_RD = iPIX_VALID & ~w_start_fall &
                   ((r_state == ST_PRIME) | (r_state == ST_FETCH));

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state      <= ST_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_wait       <= '0;
      r_img_bit    <= 1'b0;
      r_ack        <= 1'b0;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (w_start_fall) begin
      r_state      <= ST_IDLE;
      r_frame_done <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_frame_done <= 1'b0;
          if (w_start_rise) begin
            r_row      <= '0;
            r_col      <= '0;
            r_underrun <= 1'b0;
            r_overrun  <= 1'b0;
            r_state    <= ST_PRIME;
          end
        end
        ST_PRIME: begin
          if (w_req_edge) r_overrun <= 1'b1;
          if (iPIX_VALID) begin
            r_img_bit <= iPIX_DATA[BIT_SEL];
            r_ack     <= w_req_s;
            r_state   <= ST_READY;
          end
        end
        ST_READY: begin
          if (w_req_edge) begin
            r_wait <= '0;
            if (r_row == LAST_ROW && r_col == LAST_COL) begin
              r_frame_done <= 1'b1;
              r_state      <= ST_DONE;
            end else if (r_col == LAST_COL) begin
              r_col   <= '0;
              r_row   <= r_row + 10'd1;
              r_state <= ST_FETCH;
            end else begin
              r_col   <= r_col + 10'd1;
              r_state <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          // A request while the previous one is still outstanding is dropped.
          if (w_req_edge) r_overrun <= 1'b1;
          if (iPIX_VALID) begin
            r_img_bit <= iPIX_DATA[BIT_SEL];
            r_ack     <= w_req_s;
            r_state   <= ST_READY;
          end else begin
            if (r_wait != WAIT_MAX) r_wait <= r_wait + 1'b1;
            if (r_wait >= WAIT_LIM) r_underrun <= 1'b1;
          end
        end
        ST_DONE: begin
          if (w_req_edge) r_overrun <= 1'b1;
          if (w_start_rise) begin
            r_row        <= '0;
            r_col        <= '0;
            r_underrun   <= 1'b0;
            r_overrun    <= 1'b0;
            r_frame_done <= 1'b0;
            r_state      <= ST_PRIME;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign oIMG_BIT    = r_img_bit;
  assign oACK        = r_ack;
  assign oROW        = r_row;
  assign oCOL        = r_col;
  assign oFRAME_DONE = r_frame_done;
  assign oSTATE      = r_state;
  assign oUNDERRUN   = r_underrun;
  assign oOVERRUN    = r_overrun;

endmodule

// File: tb/tb_hps_pixel_responder.sv
// Bench for hps_pixel_responder: directed protocol scenarios plus a random
// phase, all compared every cycle against a pixel-index protocol model.
module tb_hps_pixel_responder;
  import hps_if_pkg::*;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int BS = 0;
  localparam int S  = 2;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst, hps, start, valid;
  logic [15:0] data;
  logic        oPIX_RD, oIMG_BIT, oACK, oFRAME_DONE, oUNDERRUN, oOVERRUN;
  logic [9:0]  oROW, oCOL;
  logic [2:0]  oSTATE;

  hps_pixel_responder #(
    .H_ACTIVE(H), .V_ACTIVE(V), .BIT_SEL(BS), .SYNC_STAGES(S), .TIMEOUT(TO)
  ) dut (
    .iCLK(clk), .iRST(rst), .iHPS_CLK(hps), .iSTART(start),
    .iPIX_DATA(data), .iPIX_VALID(valid), .oPIX_RD(oPIX_RD),
    .oIMG_BIT(oIMG_BIT), .oACK(oACK), .oROW(oROW), .oCOL(oCOL),
    .oFRAME_DONE(oFRAME_DONE), .oSTATE(oSTATE),
    .oUNDERRUN(oUNDERRUN), .oOVERRUN(oOVERRUN)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int d_pops  = 0;
  int m_pops  = 0;
  bit chk_en  = 1'b0;
  bit fix_data = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pin histories stand in for the synchronisers, the frame
  // position is a single pixel index, phases use the published encodings.
  logic hc[0:S];
  logic hs[0:S];
  int   m_phase, m_idx, m_wait;
  logic m_bit, m_ack, m_under, m_over;
  logic e_rs, e_edge, e_rise, e_fall;

  function automatic logic exp_rd();
    return valid && (m_phase == 1 || m_phase == 3) && !(hs[S-1] == 1'b0 && hs[S] == 1'b1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= S; k++) begin hc[k] = 1'b0; hs[k] = 1'b0; end
      m_phase = 0; m_idx = 0; m_wait = 0;
      m_bit = 1'b0; m_ack = 1'b0; m_under = 1'b0; m_over = 1'b0;
    end else begin
      e_rs   = hc[S-1];
      e_edge = hc[S-1] ^ hc[S];
      e_rise = hs[S-1] & ~hs[S];
      e_fall = ~hs[S-1] & hs[S];
      if (exp_rd()) m_pops++;
      if (e_fall) m_phase = 0;
      else begin
        case (m_phase)
          0: if (e_rise) begin m_idx = 0; m_under = 0; m_over = 0; m_phase = 1; end
          1: begin
            if (e_edge) m_over = 1;
            if (valid) begin m_bit = data[BS]; m_ack = e_rs; m_phase = 2; end
          end
          2: if (e_edge) begin
            if (m_idx == H * V - 1) m_phase = 4;
            else begin m_idx++; m_wait = 0; m_phase = 3; end
          end
          3: begin
            if (e_edge) m_over = 1;
            if (valid) begin m_bit = data[BS]; m_ack = e_rs; m_phase = 2; end
            else begin m_wait++; if (m_wait >= TO) m_under = 1; end
          end
          4: begin
            if (e_edge) m_over = 1;
            if (e_rise) begin m_idx = 0; m_under = 0; m_over = 0; m_phase = 1; end
          end
          default: ;
        endcase
      end
      for (int k = S; k > 0; k--) begin hc[k] = hc[k-1]; hs[k] = hs[k-1]; end
      hc[0] = hps;
      hs[0] = start;
    end
  end

  always @(negedge clk) begin
    if (oPIX_RD === 1'b1) d_pops++;
    if (chk_en) begin
      chk("rd",    oPIX_RD,     exp_rd());
      chk("state", oSTATE,      m_phase);
      chk("bit",   oIMG_BIT,    m_bit);
      chk("ack",   oACK,        m_ack);
      chk("row",   oROW,        m_idx / H);
      chk("col",   oCOL,        m_idx % H);
      chk("done",  oFRAME_DONE, m_phase == 4);
      chk("under", oUNDERRUN,   m_under);
      chk("over",  oOVERRUN,    m_over);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (!fix_data) data = 16'($urandom);
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input string nm, output int n);
    bit got = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      cyc(1); n++;
      if (oSTATE == st) got = 1'b1;
    end
    chk(nm, got, 1'b1);
  endtask

  task automatic toggle_wait(input string nm, output int n);
    bit got = 1'b0;
    hps = ~hps;
    n = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      cyc(1); n++;
      if ((oSTATE == 3'd2 && oACK == hps) || oSTATE == 3'd4) got = 1'b1;
    end
    chk(nm, got, 1'b1);
  endtask

  int n, p0, p1;
  int exp_col[4] = '{1, 2, 3, 0};
  int exp_row[4] = '{0, 0, 0, 1};

  initial begin
    hps = 1'b0; start = 1'b0; valid = 1'b0; data = 16'h0; rst = 1'b0;
    #1 rst = 1'b1;
    chk_en = 1'b1;
    cyc(3);
    chk("rst_state", oSTATE, 0);
    chk("rst_rd",    oPIX_RD, 0);
    chk("rst_ack",   oACK, 0);
    chk("rst_pos",   {oROW, oCOL}, 0);
    chk("rst_flags", {oFRAME_DONE, oUNDERRUN, oOVERRUN, oIMG_BIT}, 0);
    rst = 1'b0;
    cyc(2);

    // Start and first pixel
    p0 = d_pops;
    data = 16'h0001; valid = 1'b1; start = 1'b1;
    wait_state(3'd2, "start_ready", n);
    chk("start_cycles", n, 4);
    chk("start_pops", d_pops - p0, 1);
    chk("start_bit", oIMG_BIT, 1);
    chk("start_ack", oACK, 0);
    chk("start_pos", {oROW, oCOL}, 0);
    fix_data = 1'b0;

    // Row wrap, ack latency from toggle
    for (int t = 0; t < 4; t++) begin
      toggle_wait("wrap_ack", n);
      if (t == 0) chk("ack_latency", n, 4);
      chk("wrap_col", oCOL, exp_col[t]);
      chk("wrap_row", oROW, exp_row[t]);
    end

    // Frame end and overrun in DONE
    for (int t = 0; t < 4; t++) toggle_wait("end_ack", n);
    chk("end_state", oSTATE, 4);
    chk("end_done", oFRAME_DONE, 1);
    chk("end_pops", d_pops - p0, 8);
    hps = ~hps;
    cyc(6);
    chk("end_overrun", oOVERRUN, 1);
    chk("end_no_pop", d_pops - p0, 8);

    // New frame, then underrun
    start = 1'b0;
    wait_state(3'd0, "abort_idle", n);
    start = 1'b1;
    wait_state(3'd2, "restart_ready", n);
    chk("restart_flags", {oUNDERRUN, oOVERRUN, oFRAME_DONE}, 0);
    chk("restart_pos", {oROW, oCOL}, 0);
    p1 = d_pops;
    valid = 1'b0;
    hps = ~hps;
    wait_state(3'd3, "under_fetch", n);
    cyc(14);
    chk("under_early", oUNDERRUN, 0);
    cyc(1);
    chk("under_set", oUNDERRUN, 1);
    chk("under_no_pop", d_pops - p1, 0);
    valid = 1'b1;
    wait_state(3'd2, "under_recover", n);
    chk("under_pop", d_pops - p1, 1);
    chk("under_ack", oACK, hps);
    chk("under_sticky", oUNDERRUN, 1);

    // Overrun: two toggles on consecutive cycles
    p1 = d_pops;
    hps = ~hps;
    cyc(1);
    hps = ~hps;
    cyc(8);
    chk("ovr_flag", oOVERRUN, 1);
    chk("ovr_pops", d_pops - p1, 1);
    chk("ovr_col", oCOL, 2);

    // Abort while fetching with FIFO empty
    p1 = d_pops;
    valid = 1'b0;
    hps = ~hps;
    wait_state(3'd3, "abort_fetch", n);
    start = 1'b0;
    wait_state(3'd0, "abort_to_idle", n);
    chk("abort_no_pop", d_pops - p1, 0);
    chk("abort_col_hold", oCOL, 3);

    // Asynchronous reset mid-frame
    valid = 1'b1; start = 1'b1;
    wait_state(3'd2, "pre_rst_ready", n);
    hps = ~hps; cyc(1); hps = ~hps; cyc(8);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", oSTATE, 0);
    chk("arst_pos", {oROW, oCOL}, 0);
    chk("arst_flags", {oFRAME_DONE, oUNDERRUN, oOVERRUN, oACK, oIMG_BIT, oPIX_RD}, 0);
    start = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(2);
    start = 1'b1;
    wait_state(3'd2, "post_rst_ready", n);
    chk("post_rst_flags", {oUNDERRUN, oOVERRUN}, 0);
    chk("post_rst_pos", {oROW, oCOL}, 0);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      valid = (($urandom % 10) < 7);
      if (($urandom % 4) == 0) hps = ~hps;
      if (($urandom % 60) == 0) start = ~start;
      cyc(1);
    end
    chk("rand_pops", d_pops, m_pops);

    cyc(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
